// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin two-master Avalon-MM front end for the
// single-port on-chip RAM, with sticky per-master out-of-range flags.
module onchip_mem_arbiter #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH = 100000,
  parameter logic [DATA_W-1:0] OOR_DATA = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                err_clr,
  output logic                m0_err,
  output logic                m1_err
);

  logic req0, req1;
  logic gnt0, gnt1, gnt;
  logic last_grant;
  logic wr, rd, oor;
  logic rd_pend, rd_owner, rd_oor;
  logic [DATA_W-1:0] rdata;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // On a tie the master that did not win last time is granted.
  assign gnt1 = reset_n & req1 & (~req0 | ~last_grant);
  assign gnt0 = reset_n & req0 & ~gnt1;
  assign gnt  = gnt0 | gnt1;

  assign m0_waitrequest = reset_n & req0 & ~gnt0;
  assign m1_waitrequest = reset_n & req1 & ~gnt1;

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    wr             = m0_write;
    unique case (1'b1)
      gnt1: begin
        mem_address    = m1_address;
        mem_byteenable = m1_byteenable;
        mem_writedata  = m1_writedata;
        wr             = m1_write;
      end
      default: ;
    endcase
  end

  assign oor = 32'(mem_address) >= DEPTH;
  assign rd  = gnt & ~wr;

  assign mem_chipselect = gnt & ~oor;
  assign mem_write      = gnt & wr & ~oor;
  assign mem_clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
      rd_oor     <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      if (gnt) last_grant <= gnt1;
      rd_pend <= rd;
      if (rd) begin
        rd_owner <= gnt1;
        rd_oor   <= oor;
      end
      // A new out-of-range hit outranks a simultaneous clear.
      m0_err <= (gnt0 & oor) | (m0_err & ~err_clr);
      m1_err <= (gnt1 & oor) | (m1_err & ~err_clr);
    end
  end

  assign rdata            = rd_oor ? OOR_DATA : mem_readdata;
  assign m0_readdata      = rdata;
  assign m1_readdata      = rdata;
  assign m0_readdatavalid = rd_pend & ~rd_owner;
  assign m1_readdatavalid = rd_pend & rd_owner;

endmodule
